// File: rtl/bufown_pkg.sv
// Shared types and constants for the RX/TX buffer ownership scheduler.
// Mode encodings drive the rxbuf/txbuf address-mode muxes directly.
package bufown_pkg;

  localparam logic [1:0] MODE_CPU = 2'b00;
  localparam logic [1:0] MODE_DMA = 2'b01;
  localparam logic [1:0] MODE_ETH = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GIN,
    S_OWN,
    S_GOUT
  } state_e;

  typedef enum logic {
    REQ_DMA = 1'b0,
    REQ_ETH = 1'b1
  } req_e;

  function automatic logic [1:0] mode_of(input req_e r);
    return (r == REQ_ETH) ? MODE_ETH : MODE_DMA;
  endfunction

  function automatic req_e other(input req_e r);
    return (r == REQ_ETH) ? REQ_DMA : REQ_ETH;
  endfunction

endpackage

// File: rtl/bufown_fsm.sv
// One buffer channel: arbitration, guard turnaround, hold watchdog,
// lockout bits and the sticky timeout flag.
module bufown_fsm
  import bufown_pkg::*;
#(
  parameter int GUARD    = 2,
  parameter int HOLD_MAX = 4096,
  parameter int HW       = 13,
  parameter int ETH_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_busy,
  input  logic       dma_req,
  input  logic       eth_req,
  input  logic       tmo_clr,
  output logic       dma_gnt,
  output logic       eth_gnt,
  output logic [1:0] mode,
  output logic       tmo
);

  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam int GL = (GUARD > 0) ? GUARD - 1 : 0;
  localparam logic [GW-1:0] GEND = GW'(GL);
  localparam logic [HW-1:0] HEND = HW'(HOLD_MAX - 1);

  state_e          state, state_n;
  req_e            owner, owner_n;
  req_e            ptr, ptr_n;
  req_e            win;
  logic [GW-1:0]   gcnt, gcnt_n;
  logic [HW-1:0]   hcnt, hcnt_n;
  logic [1:0]      lock, lock_n;
  logic            tmo_q, tmo_n;
  logic            elig_dma, elig_eth;
  logic            own_req, g_done;

  assign elig_dma = dma_req & ~lock[0];
  assign elig_eth = eth_req & ~lock[1];
  assign own_req  = (owner == REQ_ETH) ? eth_req : dma_req;
  assign g_done   = (GUARD == 0) || (gcnt == GEND);

  // Winner pick: fixed ETH priority or round-robin on the pointer
  always_comb begin
    win = REQ_DMA;
    if (elig_dma && elig_eth)
      win = (ETH_PRIO != 0) ? REQ_ETH : ptr;
    else if (elig_eth)
      win = REQ_ETH;
  end

  // Next-state logic for the channel FSM and its bookkeeping
  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    gcnt_n  = gcnt;
    hcnt_n  = hcnt;
    lock_n  = lock & {eth_req, dma_req};
    tmo_n   = tmo_q & ~tmo_clr;
    unique case (state)
      S_IDLE: begin
        if ((elig_dma || elig_eth) && !cpu_busy) begin
          owner_n = win;
          gcnt_n  = '0;
          hcnt_n  = '0;
          if (GUARD == 0) begin
            state_n = S_OWN;
            ptr_n   = other(win);
          end else begin
            state_n = S_GIN;
          end
        end
      end
      S_GIN: begin
        if (!own_req) begin
          state_n = S_GOUT;
          gcnt_n  = '0;
        end else if (g_done) begin
          state_n = S_OWN;
          hcnt_n  = '0;
          ptr_n   = other(owner);
        end else begin
          gcnt_n = gcnt + GW'(1);
        end
      end
      S_OWN: begin
        if (!own_req) begin
          state_n = S_GOUT;
          gcnt_n  = '0;
        end else if (hcnt == HEND) begin
          state_n = S_GOUT;
          gcnt_n  = '0;
          tmo_n   = 1'b1;
          if (owner == REQ_ETH) lock_n[1] = 1'b1;
          else                  lock_n[0] = 1'b1;
        end else begin
          hcnt_n = hcnt + HW'(1);
        end
      end
      S_GOUT: begin
        if (g_done) state_n = S_IDLE;
        else        gcnt_n  = gcnt + GW'(1);
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Channel state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      owner <= REQ_DMA;
      ptr   <= REQ_DMA;
      gcnt  <= '0;
      hcnt  <= '0;
      lock  <= '0;
      tmo_q <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      gcnt  <= gcnt_n;
      hcnt  <= hcnt_n;
      lock  <= lock_n;
      tmo_q <= tmo_n;
    end
  end

  assign mode    = (state == S_IDLE) ? MODE_CPU : mode_of(owner);
  assign dma_gnt = (state == S_OWN) && (owner == REQ_DMA);
  assign eth_gnt = (state == S_OWN) && (owner == REQ_ETH);
  assign tmo     = tmo_q;

endmodule

// File: rtl/bufown_ctl.sv
// RX/TX packet buffer ownership scheduler: two independent channels
// sharing one timeout-clear strobe.
module bufown_ctl
  import bufown_pkg::*;
#(
  parameter int GUARD       = 2,
  parameter int HOLD_MAX    = 4096,
  parameter int HW          = 13,
  parameter int RX_ETH_PRIO = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_cpu_busy_i,
  input  logic       rx_dma_req_i,
  output logic       rx_dma_gnt_o,
  input  logic       rx_eth_req_i,
  output logic       rx_eth_gnt_o,
  output logic [1:0] rx_mode_o,
  output logic       rx_tmo_o,
  input  logic       tx_cpu_busy_i,
  input  logic       tx_dma_req_i,
  output logic       tx_dma_gnt_o,
  input  logic       tx_eth_req_i,
  output logic       tx_eth_gnt_o,
  output logic [1:0] tx_mode_o,
  output logic       tx_tmo_o,
  input  logic       tmo_clr_i
);

  bufown_fsm #(
    .GUARD(GUARD), .HOLD_MAX(HOLD_MAX),
    .HW(HW), .ETH_PRIO(RX_ETH_PRIO)
  ) u_rx (
    .clk(clk_i), .rst(rst_i),
    .cpu_busy(rx_cpu_busy_i),
    .dma_req(rx_dma_req_i), .eth_req(rx_eth_req_i),
    .tmo_clr(tmo_clr_i),
    .dma_gnt(rx_dma_gnt_o), .eth_gnt(rx_eth_gnt_o),
    .mode(rx_mode_o), .tmo(rx_tmo_o)
  );

  bufown_fsm #(
    .GUARD(GUARD), .HOLD_MAX(HOLD_MAX),
    .HW(HW), .ETH_PRIO(0)
  ) u_tx (
    .clk(clk_i), .rst(rst_i),
    .cpu_busy(tx_cpu_busy_i),
    .dma_req(tx_dma_req_i), .eth_req(tx_eth_req_i),
    .tmo_clr(tmo_clr_i),
    .dma_gnt(tx_dma_gnt_o), .eth_gnt(tx_eth_gnt_o),
    .mode(tx_mode_o), .tmo(tx_tmo_o)
  );

endmodule

// File: tb/tb_bufown_ctl.sv
// Directed scoreboard bench for bufown_ctl: a GUARD=2 instance and a
// GUARD=0 instance, both with HOLD_MAX=16, driven from shared inputs.
module tb_bufown_ctl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_busy = 0, rx_dreq = 0, rx_ereq = 0;
  logic tx_busy = 0, tx_dreq = 0, tx_ereq = 0;
  logic tmo_clr = 0;

  logic       rx_dg, rx_eg, rx_tmo, tx_dg, tx_eg, tx_tmo;
  logic [1:0] rx_mode, tx_mode;
  logic       z_rx_dg, z_rx_eg, z_rx_tmo, z_tx_dg, z_tx_eg, z_tx_tmo;
  logic [1:0] z_rx_mode, z_tx_mode;

  always #5 clk = ~clk;

  bufown_ctl #(.GUARD(2), .HOLD_MAX(16), .HW(5), .RX_ETH_PRIO(1)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .rx_cpu_busy_i(rx_busy), .rx_dma_req_i(rx_dreq),
    .rx_dma_gnt_o(rx_dg), .rx_eth_req_i(rx_ereq),
    .rx_eth_gnt_o(rx_eg), .rx_mode_o(rx_mode), .rx_tmo_o(rx_tmo),
    .tx_cpu_busy_i(tx_busy), .tx_dma_req_i(tx_dreq),
    .tx_dma_gnt_o(tx_dg), .tx_eth_req_i(tx_ereq),
    .tx_eth_gnt_o(tx_eg), .tx_mode_o(tx_mode), .tx_tmo_o(tx_tmo),
    .tmo_clr_i(tmo_clr)
  );

  bufown_ctl #(.GUARD(0), .HOLD_MAX(16), .HW(5), .RX_ETH_PRIO(1)) u_g0 (
    .clk_i(clk), .rst_i(rst),
    .rx_cpu_busy_i(rx_busy), .rx_dma_req_i(rx_dreq),
    .rx_dma_gnt_o(z_rx_dg), .rx_eth_req_i(rx_ereq),
    .rx_eth_gnt_o(z_rx_eg), .rx_mode_o(z_rx_mode), .rx_tmo_o(z_rx_tmo),
    .tx_cpu_busy_i(tx_busy), .tx_dma_req_i(tx_dreq),
    .tx_dma_gnt_o(z_tx_dg), .tx_eth_req_i(tx_ereq),
    .tx_eth_gnt_o(z_tx_eg), .tx_mode_o(z_tx_mode), .tx_tmo_o(z_tx_tmo),
    .tmo_clr_i(tmo_clr)
  );

  typedef struct {
    string      tag;
    logic [9:0] em;
    logic       g0c;
    logic [4:0] eg;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  localparam logic [4:0] I0 = 5'b00000;

  // {mode, dma_gnt, eth_gnt, tmo} for one channel
  function automatic logic [4:0] ch(input logic [1:0] m,
                                    input logic dg, input logic eg,
                                    input logic t);
    return {m, dg, eg, t};
  endfunction

  task automatic check_head();
    exp_t e;
    logic [9:0] act;
    logic [4:0] zact;
    e = sb.pop_front();
    act = {rx_mode, rx_dg, rx_eg, rx_tmo,
           tx_mode, tx_dg, tx_eg, tx_tmo};
    zact = {z_rx_mode, z_rx_dg, z_rx_eg, z_rx_tmo};
    vectors++;
    assert (act === e.em) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", e.tag, act, e.em);
    end
    if (e.g0c) begin
      vectors++;
      assert (zact === e.eg) else begin
        miscompares++;
        $error("FAIL %s_g0: observed %b expected %b",
               e.tag, zact, e.eg);
      end
    end
  endtask

  task automatic cyc(input string tag, input logic [9:0] em,
                     input logic g0c = 1'b0,
                     input logic [4:0] eg = 5'b0);
    sb.push_back('{tag, em, g0c, eg});
    @(posedge clk);
    #1;
    check_head();
  endtask

  task automatic chk_now(input string tag, input logic [9:0] em,
                         input logic g0c = 1'b0,
                         input logic [4:0] eg = 5'b0);
    sb.push_back('{tag, em, g0c, eg});
    check_head();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_now("reset", {I0, I0}, 1'b1, I0);
    rst = 1'b0;
    cyc("idle", {I0, I0});

    // RX DMA grant with two guard cycles each way
    rx_dreq = 1;
    cyc("rx_dma_mode", {ch(2'b01, 0, 0, 0), I0});
    cyc("rx_dma_gin",  {ch(2'b01, 0, 0, 0), I0});
    cyc("rx_dma_gnt",  {ch(2'b01, 1, 0, 0), I0});
    repeat (3) cyc("rx_dma_own", {ch(2'b01, 1, 0, 0), I0});
    rx_dreq = 0;
    cyc("rx_dma_rel",   {ch(2'b01, 0, 0, 0), I0});
    cyc("rx_dma_gout",  {ch(2'b01, 0, 0, 0), I0});
    cyc("rx_dma_cpu",   {I0, I0});

    // RX fixed ETH priority
    rx_dreq = 1; rx_ereq = 1;
    cyc("rx_prio_mode", {ch(2'b10, 0, 0, 0), I0});
    cyc("rx_prio_gin",  {ch(2'b10, 0, 0, 0), I0});
    cyc("rx_prio_gnt",  {ch(2'b10, 0, 1, 0), I0});
    rx_dreq = 0; rx_ereq = 0;
    cyc("rx_prio_rel",  {ch(2'b10, 0, 0, 0), I0});
    cyc("rx_prio_gout", {ch(2'b10, 0, 0, 0), I0});
    cyc("rx_prio_cpu",  {I0, I0});

    // TX round-robin: DMA first, then ETH
    tx_dreq = 1; tx_ereq = 1;
    cyc("tx_rr_dma_mode", {I0, ch(2'b01, 0, 0, 0)});
    cyc("tx_rr_dma_gin",  {I0, ch(2'b01, 0, 0, 0)});
    cyc("tx_rr_dma_gnt",  {I0, ch(2'b01, 1, 0, 0)});
    tx_dreq = 0;
    cyc("tx_rr_dma_rel",  {I0, ch(2'b01, 0, 0, 0)});
    cyc("tx_rr_dma_gout", {I0, ch(2'b01, 0, 0, 0)});
    cyc("tx_rr_cpu",      {I0, I0});
    cyc("tx_rr_eth_mode", {I0, ch(2'b10, 0, 0, 0)});
    cyc("tx_rr_eth_gin",  {I0, ch(2'b10, 0, 0, 0)});
    cyc("tx_rr_eth_gnt",  {I0, ch(2'b10, 0, 1, 0)});
    tx_ereq = 0;
    cyc("tx_rr_eth_rel",  {I0, ch(2'b10, 0, 0, 0)});
    cyc("tx_rr_eth_gout", {I0, ch(2'b10, 0, 0, 0)});
    cyc("tx_rr_eth_cpu",  {I0, I0});

    // CPU cycle blocks the arbitration
    tx_busy = 1; tx_ereq = 1;
    repeat (5) cyc("tx_busy_wait", {I0, I0});
    tx_busy = 0;
    cyc("tx_busy_mode", {I0, ch(2'b10, 0, 0, 0)});
    cyc("tx_busy_gin",  {I0, ch(2'b10, 0, 0, 0)});
    cyc("tx_busy_gnt",  {I0, ch(2'b10, 0, 1, 0)});
    tx_ereq = 0;
    cyc("tx_busy_rel",  {I0, ch(2'b10, 0, 0, 0)});
    cyc("tx_busy_gout", {I0, ch(2'b10, 0, 0, 0)});
    cyc("tx_busy_cpu",  {I0, I0});

    // hold timeout, lockout and sticky flag
    rx_dreq = 1;
    repeat (2) cyc("tmo_gin", {ch(2'b01, 0, 0, 0), I0});
    repeat (16) cyc("tmo_own", {ch(2'b01, 1, 0, 0), I0});
    cyc("tmo_set",  {ch(2'b01, 0, 0, 1), I0});
    cyc("tmo_gout", {ch(2'b01, 0, 0, 1), I0});
    cyc("tmo_cpu",  {ch(2'b00, 0, 0, 1), I0});
    repeat (3) cyc("tmo_lockout", {ch(2'b00, 0, 0, 1), I0});
    rx_dreq = 0;
    cyc("tmo_unlock", {ch(2'b00, 0, 0, 1), I0});
    tmo_clr = 1;
    cyc("tmo_clr", {I0, I0});
    tmo_clr = 0;
    rx_dreq = 1;
    repeat (2) cyc("tmo2_gin", {ch(2'b01, 0, 0, 0), I0});
    repeat (16) cyc("tmo2_own", {ch(2'b01, 1, 0, 0), I0});
    tmo_clr = 1;
    cyc("tmo_clr_vs_set", {ch(2'b01, 0, 0, 1), I0});
    tmo_clr = 0;
    rx_dreq = 0;
    cyc("tmo2_gout", {ch(2'b01, 0, 0, 1), I0});
    cyc("tmo2_cpu",  {ch(2'b00, 0, 0, 1), I0});

    // asynchronous reset in the middle of ownership
    rx_ereq = 1; tx_dreq = 1;
    repeat (2) cyc("ar_gin",
                   {ch(2'b10, 0, 0, 1), ch(2'b01, 0, 0, 0)});
    cyc("ar_own", {ch(2'b10, 0, 1, 1), ch(2'b01, 1, 0, 0)});
    #3;
    rst = 1;
    #1;
    chk_now("async_rst", {I0, I0}, 1'b1, I0);
    @(posedge clk);
    #1;
    rst = 0;
    repeat (2) cyc("ar_resume_gin",
                   {ch(2'b10, 0, 0, 0), ch(2'b01, 0, 0, 0)});
    cyc("ar_resume_gnt", {ch(2'b10, 0, 1, 0), ch(2'b01, 1, 0, 0)});
    rx_ereq = 0; tx_dreq = 0;
    repeat (2) cyc("ar_rel",
                   {ch(2'b10, 0, 0, 0), ch(2'b01, 0, 0, 0)});
    cyc("ar_cpu", {I0, I0}, 1'b1, I0);

    // GUARD=0: req drop on the last allowed hold cycle
    rx_dreq = 1;
    cyc("g0_gnt", {ch(2'b01, 0, 0, 0), I0},
        1'b1, ch(2'b01, 1, 0, 0));
    cyc("g0_hold", {ch(2'b01, 0, 0, 0), I0},
        1'b1, ch(2'b01, 1, 0, 0));
    repeat (14) cyc("g0_own", {ch(2'b01, 1, 0, 0), I0},
                    1'b1, ch(2'b01, 1, 0, 0));
    rx_dreq = 0;
    cyc("g0_rel", {ch(2'b01, 0, 0, 0), I0},
        1'b1, ch(2'b01, 0, 0, 0));
    cyc("g0_cpu", {ch(2'b01, 0, 0, 0), I0}, 1'b1, I0);
    cyc("g0_idle", {I0, I0}, 1'b1, I0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bufown_ctl.md
Name: bufown_ctl

Overview:
- Ownership scheduler for the RX and TX packet buffer memories. Each buffer is shared between three requesters: the local CPU (the default owner), the DMA engine and the Ethernet MAC.
- Generates the per-buffer address-mode selects ({eth,dma}) that drive the buffer muxes. This replaces ad-hoc mode bits set by firmware.
- Each buffer gets request/grant handshakes, guard (turnaround) cycles, a hold watchdog and sticky timeout flags.
- Sits between dma, ether, extregs and the rxbuf/txbuf memories. Two independent channel FSMs.

Parameters:
- GUARD, 2: turnaround cycles between a mode change and a grant, and between a grant release and the return to CPU mode; 0 is legal.
- HOLD_MAX, 4096: maximum consecutive cycles one owner may hold a buffer.
- HW, 13: width of the hold counter; must satisfy 2^HW > HOLD_MAX.
- RX_ETH_PRIO, 1: 1 means the RX channel's Ethernet requester always beats DMA; 0 means round-robin.

Ports:
- clk_i  in  1  system clock; all inputs synchronous to it.
- rst_i  in  1  reset, asynchronous, active-high.
- rx_cpu_busy_i  in  1  CPU wishbone cycle currently active on rxbuf.
- rx_dma_req_i  in  1  DMA requests the RX buffer (level).
- rx_dma_gnt_o  out  1  DMA owns the RX buffer.
- rx_eth_req_i  in  1  MAC requests the RX buffer (level).
- rx_eth_gnt_o  out  1  MAC owns the RX buffer.
- rx_mode_o  out  2  rxbuf adr_mode: 00 CPU, 01 DMA, 10 ETH.
- rx_tmo_o  out  1  sticky RX hold-timeout flag.
- tx_cpu_busy_i, tx_dma_req_i, tx_dma_gnt_o, tx_eth_req_i, tx_eth_gnt_o, tx_mode_o[1:0], tx_tmo_o: same meanings for the TX channel.
- tmo_clr_i  in  1  clears both timeout flags (one-cycle pulse from extregs).

Behaviour:
- Reset (asynchronous, immediate): both FSMs go to IDLE. All gnt outputs 0, mode_o 00, tmo flags 0, counters 0, lockout bits 0, round-robin pointer pointing at DMA.
- mode_o is never 11. At most one gnt per channel is high. A gnt is high only while mode_o matches the grantee.
- FSM states per channel: IDLE, GIN (guard-in), OWN, GOUT (guard-out).
- IDLE:
  - mode 00, gnts 0.
  - When any eligible request is high and cpu_busy is 0 at edge N, latch the winner and go to GIN.
  - mode_o shows the winner from cycle N+1.
  - A request arriving while cpu_busy=1 waits; there is no pre-emption of a CPU cycle.
- Winner selection:
  - RX with RX_ETH_PRIO=1: ETH wins.
  - Otherwise round-robin: the requester not served last wins; the pointer updates on entry to OWN.
  - An eligible request is one that is high and whose lockout bit is 0.
- GIN:
  - Counts GUARD cycles, then goes to OWN.
  - gnt rises at cycle N+1+GUARD. With GUARD=0 the FSM skips GIN and gnt rises at N+1.
  - If the winner's request drops during GIN, go to GOUT without granting.
- OWN:
  - gnt held high; hold counter increments every cycle from 0.
  - Requester drops req at edge M: gnt=0 at M+1, go to GOUT.
  - Hold counter reaches HOLD_MAX-1 with req still high: gnt drops, tmo flag set, owner's lockout bit set, go to GOUT.
  - If req drop and timeout occur on the same edge: normal release, no tmo, no lockout.
- GOUT:
  - mode_o holds the previous owner's value for GUARD cycles, then returns to 00 and the FSM enters IDLE.
  - GUARD=0 means mode returns to 00 the cycle after the gnt drops.
  - The CPU regains the buffer only after GOUT completes.
- Lockout: a requester's lockout bit clears on the first cycle its req is low. While set, that requester is ineligible.
- Timeout flags:
  - tmo flags are sticky; tmo_clr_i clears both.
  - If a set and a clear occur on the same edge, set wins.
- Channels are fully independent; simultaneous activity on RX and TX is legal.
- Requests that stay high are not re-arbitrated while in OWN. A new arbitration starts only from IDLE.

Decomposition:
- Package bufown_pkg:
  - mode constants MODE_CPU=2'b00, MODE_DMA=2'b01, MODE_ETH=2'b10.
  - state encoding IDLE/GIN/OWN/GOUT.
  - requester index enum.
- Sub-module bufown_fsm (parameters GUARD, HOLD_MAX, HW, ETH_PRIO) holds one channel's FSM, counters, lockout bits and pointer.
- bufown_ctl instantiates bufown_fsm twice (RX with ETH_PRIO=RX_ETH_PRIO, TX with ETH_PRIO=0) and the shared tmo-clear fan-out.

Test Plan:
- GUARD=2, rx_dma_req_i high at edge 10, cpu_busy=0 -> rx_mode_o=01 from cycle 11, rx_dma_gnt_o=1 from cycle 13; req low at edge 20 -> gnt=0 at 21, rx_mode_o=00 at 23.
- rx_eth_req_i and rx_dma_req_i raised on the same cycle, RX_ETH_PRIO=1 -> ETH granted, rx_mode_o=10; TX with both requests, pointer at DMA -> DMA first, ETH second after DMA releases.
- tx_cpu_busy_i held high for 5 cycles while tx_eth_req_i is high -> tx_mode_o stays 00 and no grant; mode changes the cycle after busy falls.
- HOLD_MAX=16 with DMA req held -> gnt drops after 16 cycles and rx_tmo_o=1; DMA is not re-granted until its req toggles low; tmo_clr_i pulse -> rx_tmo_o=0; clear coincident with a new timeout -> flag stays 1.
- rst_i asserted asynchronously mid-OWN -> all gnts 0 and both mode_o=00 before the next clock edge; normal arbitration resumes after release.
- GUARD=0, DMA req drops on exactly the HOLD_MAX-th cycle -> normal release with no tmo; grant and mode return occur one cycle after the respective events.
